tsn_tx_arbiter: RTL

TSN_TX_ARBITER -- requirements
Module: tsn_tx_arbiter

---
 rtl/tsn_tx_arb_pkg.sv | 19 +
 rtl/tsn_tx_ifg_timer.sv | 31 +++
 rtl/tsn_tx_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tsn_tx_arb_pkg.sv
// Shared types and default configuration for the TSN transmit arbiter.
package tsn_tx_arb_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_IFG_CYCLES   = 12;
  localparam int DEF_STARVE_LIMIT = 4;

  // IFG counter and starve counter widths; both parameters are limited to 0..255
  localparam int IFG_CNT_W    = 8;
  localparam int STARVE_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_PTP = 2'd1,
    GNT_BE  = 2'd2,
    IFG     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/tsn_tx_ifg_timer.sv
// Inter-frame gap timer: loaded at the end of a frame, counts down one step
// per clock and pulses done during the last gap clock.
module tsn_tx_ifg_timer
  import tsn_tx_arb_pkg::*;
#(
  parameter int CNT_W = IFG_CNT_W
) (
  input  logic             mac_axis_aclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Reload on frame end, otherwise count down and rest at zero
  always_ff @(posedge mac_axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A load of N gives N gap clocks; done marks the final one
  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/tsn_tx_arbiter.sv
// Two-source AXI-Stream transmit arbiter: PTP event frames take priority over
// best-effort frames, ownership changes only at frame boundaries, and an
// inter-frame gap is inserted after every frame.
// Optional build macro TSN_TX_ARB_STARVE_GUARD_EN: after STARVE_LIMIT PTP
// grants made while best-effort was waiting, best-effort gets the next grant.
module tsn_tx_arbiter
  import tsn_tx_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int IFG_CYCLES   = DEF_IFG_CYCLES,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  mac_axis_aclk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ptp_axis_tdata,
  input  logic                  ptp_axis_tvalid,
  input  logic                  ptp_axis_tlast,
  output logic                  ptp_axis_tready,
  input  logic [DATA_WIDTH-1:0] be_axis_tdata,
  input  logic                  be_axis_tvalid,
  input  logic                  be_axis_tlast,
  output logic                  be_axis_tready,
  output logic [DATA_WIDTH-1:0] mac_axis_out_tdata,
  output logic                  mac_axis_out_tvalid,
  output logic                  mac_axis_out_tlast,
  input  logic                  mac_axis_out_tready,
  output logic                  grant_ptp,
  output logic [15:0]           ptp_frame_cnt,
  output logic [15:0]           be_frame_cnt
);

  if (IFG_CYCLES < 0 || IFG_CYCLES > 255) begin : g_bad_ifg
    $error("tsn_tx_arbiter: IFG_CYCLES must be within 0..255");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve
    $error("tsn_tx_arbiter: STARVE_LIMIT must be within 1..255");
  end

  localparam logic [IFG_CNT_W-1:0] IFG_LOAD = IFG_CNT_W'(IFG_CYCLES);

  arb_state_e state;
  logic       ptp_frame_end;
  logic       be_frame_end;
  logic       ifg_done;
  logic       force_be;
  logic       pick_ptp;
  logic       pick_be;

  assign ptp_frame_end = (state == GNT_PTP) && ptp_axis_tvalid && mac_axis_out_tready && ptp_axis_tlast;
  assign be_frame_end  = (state == GNT_BE)  && be_axis_tvalid  && mac_axis_out_tready && be_axis_tlast;

`ifdef TSN_TX_ARB_STARVE_GUARD_EN
  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt;

  assign force_be = (starve_cnt == STARVE_MAX);

  // Count PTP grants that made a waiting best-effort source wait longer
  always_ff @(posedge mac_axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_ptp && be_axis_tvalid) begin
        starve_cnt <= starve_cnt + 1'b1;
      end else if (pick_be) begin
        starve_cnt <= '0;
      end
    end
  end
`else
  assign force_be = 1'b0;
`endif

  // Arbitration decision, only acted upon in IDLE
  assign pick_ptp = ptp_axis_tvalid && !(be_axis_tvalid && force_be);
  assign pick_be  = be_axis_tvalid && !pick_ptp;

  // Frame gap countdown
  tsn_tx_ifg_timer #(
    .CNT_W (IFG_CNT_W)
  ) u_ifg_timer (
    .mac_axis_aclk (mac_axis_aclk),
    .rst_n         (rst_n),
    .load          (ptp_frame_end || be_frame_end),
    .load_val      (IFG_LOAD),
    .done          (ifg_done)
  );

  // Grant FSM with registered grant flag and completed-frame counters
  always_ff @(posedge mac_axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_ptp     <= 1'b0;
      ptp_frame_cnt <= '0;
      be_frame_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_ptp) begin
            state     <= GNT_PTP;
            grant_ptp <= 1'b1;
          end else if (pick_be) begin
            state <= GNT_BE;
          end
        end
        GNT_PTP: begin
          if (ptp_frame_end) begin
            ptp_frame_cnt <= ptp_frame_cnt + 16'd1;
            grant_ptp     <= 1'b0;
            state         <= (IFG_CYCLES > 0) ? IFG : IDLE;
          end
        end
        GNT_BE: begin
          if (be_frame_end) begin
            be_frame_cnt <= be_frame_cnt + 16'd1;
            state        <= (IFG_CYCLES > 0) ? IFG : IDLE;
          end
        end
        IFG: begin
          if (ifg_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          grant_ptp <= 1'b0;
        end
      endcase
    end
  end

  // Output mux: the owner passes straight through, everything is quiet otherwise
  always_comb begin
    mac_axis_out_tdata  = '0;
    mac_axis_out_tvalid = 1'b0;
    mac_axis_out_tlast  = 1'b0;
    ptp_axis_tready     = 1'b0;
    be_axis_tready      = 1'b0;
    case (state)
      GNT_PTP: begin
        mac_axis_out_tdata  = ptp_axis_tdata;
        mac_axis_out_tvalid = ptp_axis_tvalid;
        mac_axis_out_tlast  = ptp_axis_tlast;
        ptp_axis_tready     = mac_axis_out_tready;
      end
      GNT_BE: begin
        mac_axis_out_tdata  = be_axis_tdata;
        mac_axis_out_tvalid = be_axis_tvalid;
        mac_axis_out_tlast  = be_axis_tlast;
        be_axis_tready      = mac_axis_out_tready;
      end
      default: begin
      end
    endcase
  end

endmodule
